// File: rtl/isqrt_staged.sv
// isqrt_staged
// ------------
// Pipelined integer square-root responder: y = floor(sqrt(x)) with a fixed
// latency of N_STAGES cycles and one new argument accepted every cycle.
//
// Parameters
//   N_STAGES : register stages (= latency in cycles). Legal: 1, 2, 4, 8, 16.
//              Each stage runs 16/N_STAGES root-bit iterations combinationally.
//
// Ports
//   clk   in   1  rising-edge clock
//   rst   in   1  synchronous active-high reset (clears the valid chain only)
//   x_vld in   1  argument valid, one-cycle qualifier
//   x     in  32  unsigned argument, sampled when x_vld=1
//   y_vld out  1  result valid, one-cycle pulse per accepted argument
//   y     out 16  floor(sqrt(x)); meaningful only while y_vld=1
//
// Handshake: valid-only, no ready. Every cycle with x_vld=1 and rst=0 is an
// accepted argument; it is never stalled or dropped, and its result appears
// as a single y_vld=1 cycle exactly N_STAGES cycles later, in acceptance
// order. Data registers are not reset; y is undefined whenever y_vld=0.

module isqrt_staged #(
  parameter int N_STAGES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y
);

  localparam int ITERS = 16 / N_STAGES;

  typedef struct packed {
    logic [31:0] rem;
    logic [31:0] root;
  } sq_t;

  // Restoring digit-by-digit square root, ITERS iterations starting at
  // global iteration index 'first'. The bit weight m for iteration i is
  // 1 << (30 - 2*i), so it is a constant per stage and never stored.
  function automatic sq_t run_iters(input sq_t s_in, input int first);
    sq_t         s;
    logic [31:0] m;
    logic [31:0] b;
    s = s_in;
    for (int i = 0; i < ITERS; i++) begin
      m      = 32'd1 << (30 - 2 * (first + i));
      b      = s.root | m;
      s.root = s.root >> 1;
      if (s.rem >= b) begin
        s.rem  = s.rem - b;
        s.root = s.root | m;
      end
    end
    return s;
  endfunction

  sq_t  st_q   [N_STAGES];
  logic vld_q  [N_STAGES];
  sq_t  st_in  [N_STAGES];
  sq_t  st_nxt [N_STAGES];
  logic vld_in [N_STAGES];

  // Stage inputs: stage 0 takes the new argument, stage k takes stage k-1.
  always_comb begin
    st_in[0]  = '{rem: x, root: 32'd0};
    vld_in[0] = x_vld;
    for (int k = 1; k < N_STAGES; k++) begin
      st_in[k]  = st_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
    for (int k = 0; k < N_STAGES; k++) begin
      st_nxt[k] = run_iters(st_in[k], k * ITERS);
    end
  end

  // Only the valid chain is reset; data registers load only behind a valid
  // so idle stages do not toggle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_STAGES; k++) begin
      if (rst) begin
        vld_q[k] <= 1'b0;
      end else begin
        vld_q[k] <= vld_in[k];
      end
      if (vld_in[k]) begin
        st_q[k] <= st_nxt[k];
      end
    end
  end

  assign y_vld = vld_q[N_STAGES-1];
  assign y     = st_q[N_STAGES-1].root[15:0];

  // The final remainder and the upper root bits are not part of the result.
  logic unused_bits;
  assign unused_bits = ^{st_q[N_STAGES-1].rem, st_q[N_STAGES-1].root[31:16]};

endmodule
